// File: rtl/microc_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXECUTE sequencer for the microc datapath, with a
// program-memory ready handshake, run/step/halt debug control and status counters.
module microc_seq_ctrl #(
  parameter int COUNT_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               run,
  input  logic               step,
  output logic               ir_load,
  output logic               pc_en,
  output logic               s_inc,
  output logic               s_inm,
  output logic               we,
  output logic               wez,
  output logic [2:0]         ALUOp,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {S_HALTED, S_FETCH, S_DECODE, S_EXECUTE} state_t;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_ir;
  logic               r_fault;
  logic [COUNT_W-1:0] r_count;
  logic [3:0]         r_tmo;
  logic               r_single;

  logic       w_is_alu, w_is_j, w_is_jz, w_is_jnz, w_is_halt, w_illegal;
  logic       w_tmo_hit;
  logic       w_ir_load, w_pc_en, w_s_inc, w_s_inm, w_we, w_wez;
  logic [2:0] w_alu_op;

  assign w_is_alu  = ~r_ir[5];
  assign w_is_j    = (r_ir == 6'b100000);
  assign w_is_jz   = (r_ir == 6'b100001);
  assign w_is_jnz  = (r_ir == 6'b100010);
  assign w_is_halt = (r_ir == 6'b111111);
  assign w_illegal = r_ir[5] & ~(w_is_j | w_is_jz | w_is_jnz | w_is_halt);

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    w_tmo_hit = 1'b0;
    w_ir_load = 1'b0;
    w_pc_en   = 1'b0;
    w_s_inc   = 1'b1;
    w_s_inm   = 1'b0;
    w_we      = 1'b0;
    w_wez     = 1'b0;
    w_alu_op  = 3'b000;
    unique case (r_state)
      S_HALTED: if (run || step) w_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          w_ir_load = 1'b1;
          w_next    = S_DECODE;
        end else if (r_tmo == TMO_LAST) begin
          w_tmo_hit = 1'b1;
          w_next    = S_HALTED;
        end
      end
      S_DECODE: begin
        if (w_is_alu) begin
          w_alu_op = r_ir[2:0];
          w_s_inm  = r_ir[4];
        end
        w_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (w_is_alu) begin
          w_alu_op = r_ir[2:0];
          w_s_inm  = r_ir[4];
        end
        w_pc_en = 1'b1;
        w_we    = w_is_alu;
        w_wez   = w_is_alu;
        if (w_is_j)        w_s_inc = 1'b0;
        else if (w_is_jz)  w_s_inc = ~zero;
        else if (w_is_jnz) w_s_inc = zero;
        w_next = (run && !r_single && !w_is_halt) ? S_FETCH : S_HALTED;
      end
      default: w_next = S_HALTED;
    endcase
    // A reset sampled mid-instruction must not leak a write or PC update.
    if (reset) begin
      w_ir_load = 1'b0;
      w_pc_en   = 1'b0;
      w_s_inc   = 1'b0;
      w_s_inm   = 1'b0;
      w_we      = 1'b0;
      w_wez     = 1'b0;
      w_alu_op  = 3'b000;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_HALTED;
      r_ir     <= 6'b000000;
      r_fault  <= 1'b0;
      r_count  <= '0;
      r_tmo    <= 4'd0;
      r_single <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ir_load) r_ir <= opcode;
      if (r_state == S_FETCH && !mem_ready && !w_tmo_hit) r_tmo <= r_tmo + 4'd1;
      else                                                r_tmo <= 4'd0;
      if (w_tmo_hit || (r_state == S_EXECUTE && w_illegal)) r_fault <= 1'b1;
      if (r_state == S_EXECUTE) r_count <= r_count + COUNT_W'(1);
      // run wins over step; the one-shot is dropped once its instruction retires.
      if (r_state == S_HALTED)                               r_single <= step & ~run;
      else if (r_state == S_EXECUTE && w_next == S_HALTED)   r_single <= 1'b0;
    end
  end

  assign ir_load     = w_ir_load;
  assign pc_en       = w_pc_en;
  assign s_inc       = w_s_inc;
  assign s_inm       = w_s_inm;
  assign we          = w_we;
  assign wez         = w_wez;
  assign ALUOp       = w_alu_op;
  assign busy        = (r_state != S_HALTED);
  assign halted      = (r_state == S_HALTED);
  assign fault       = r_fault;
  assign instr_count = r_count;

endmodule

// File: tb/tb_microc_seq_ctrl.sv
// Directed bench for microc_seq_ctrl: per-cycle expected strobe vectors are
// queued as stimulus is applied and popped/compared at the falling edge.
module tb_microc_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready, run, step;
  logic [5:0]  opcode;
  logic        ir_load, pc_en, s_inc, s_inm, we, wez, busy, halted, fault;
  logic [2:0]  ALUOp;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  microc_seq_ctrl #(.COUNT_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .run(run), .step(step),
    .ir_load(ir_load), .pc_en(pc_en), .s_inc(s_inc), .s_inm(s_inm),
    .we(we), .wez(wez), .ALUOp(ALUOp), .busy(busy), .halted(halted),
    .fault(fault), .instr_count(instr_count)
  );

  typedef struct packed {
    logic       ir_load, pc_en, s_inc, s_inm, we, wez;
    logic [2:0] alu;
    logic       halted, busy;
  } vec_t;

  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t v(input logic ir, pc, inc, inm, w, wz,
                             input logic [2:0] alu, input logic h);
    return '{ir, pc, inc, inm, w, wz, alu, h, ~h};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: compare outputs at the falling edge, then advance past the rising edge.
  task automatic cyc(input string tag);
    vec_t o, e;
    @(negedge clk);
    o = {ir_load, pc_en, s_inc, s_inm, we, wez, ALUOp, halted, busy};
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: got %0h expected <empty scoreboard>", tag, o);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(o), 32'(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input string tag, input vec_t e);
    exp_q.push_back(e);
    cyc(tag);
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic z,
                           input vec_t dec, input vec_t exe);
    opcode = op;
    zero   = z;
    step1({tag, "_fetch"}, v(1, 0, 1, 0, 0, 0, 3'd0, 0));
    step1({tag, "_decode"}, dec);
    step1({tag, "_exec"}, exe);
  endtask

  vec_t v_halt, v_rst, v_wait, v_dec0, v_add;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v_halt = v(0, 0, 1, 0, 0, 0, 3'd0, 1);
    v_rst  = v(0, 0, 0, 0, 0, 0, 3'd0, 1);
    v_wait = v(0, 0, 1, 0, 0, 0, 3'd0, 0);
    v_dec0 = v(0, 0, 1, 0, 0, 0, 3'd0, 0);
    v_add  = v(0, 1, 1, 0, 1, 1, 3'd0, 0);

    reset = 1'b1; run = 1'b0; step = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0;
    @(posedge clk); #1;
    step1("reset", v_rst);
    reset = 1'b0;
    chk("reset_count", 32'(instr_count), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);

    // Free-running ALU instructions at a 3-cycle cadence.
    run = 1'b1; mem_ready = 1'b1;
    step1("start", v_halt);
    run_instr("add", 6'b000000, 1'b0, v_dec0, v_add);
    chk("count1", 32'(instr_count), 32'd1);
    run_instr("add2", 6'b000000, 1'b0, v_dec0, v_add);
    chk("count2", 32'(instr_count), 32'd2);
    run_instr("alu_r", 6'b001011, 1'b0, v(0, 0, 1, 0, 0, 0, 3'd3, 0), v(0, 1, 1, 0, 1, 1, 3'd3, 0));
    run_instr("imm", 6'b010101, 1'b0, v(0, 0, 1, 1, 0, 0, 3'd5, 0), v(0, 1, 1, 1, 1, 1, 3'd5, 0));

    // Branches: only s_inc differs in EXECUTE.
    run_instr("jz_z1", 6'b100001, 1'b1, v_dec0, v(0, 1, 0, 0, 0, 0, 3'd0, 0));
    run_instr("jz_z0", 6'b100001, 1'b0, v_dec0, v(0, 1, 1, 0, 0, 0, 3'd0, 0));
    run_instr("jnz_z1", 6'b100010, 1'b1, v_dec0, v(0, 1, 1, 0, 0, 0, 3'd0, 0));
    run_instr("jnz_z0", 6'b100010, 1'b0, v_dec0, v(0, 1, 0, 0, 0, 0, 3'd0, 0));
    run_instr("j", 6'b100000, 1'b1, v_dec0, v(0, 1, 0, 0, 0, 0, 3'd0, 0));
    chk("count9", 32'(instr_count), 32'd9);
    chk("fault_clean", 32'(fault), 32'd0);

    // Illegal opcode runs as a NOP, raises fault and keeps going.
    run_instr("illegal", 6'b110000, 1'b0, v_dec0, v(0, 1, 1, 0, 0, 0, 3'd0, 0));
    chk("illegal_fault", 32'(fault), 32'd1);
    chk("count10", 32'(instr_count), 32'd10);

    // HALT stops even though run stays high.
    run_instr("halt", 6'b111111, 1'b0, v_dec0, v(0, 1, 1, 0, 0, 0, 3'd0, 0));
    chk("count11", 32'(instr_count), 32'd11);
    step1("halt_stop", v_halt);

    // run dropped during DECODE: the instruction completes, then halts.
    opcode = 6'b000000;
    step1("drop_fetch", v(1, 0, 1, 0, 0, 0, 3'd0, 0));
    run = 1'b0;
    step1("drop_decode", v_dec0);
    step1("drop_exec", v_add);
    step1("drop_halt", v_halt);
    step1("drop_stay", v_halt);
    chk("count12", 32'(instr_count), 32'd12);
    chk("fault_sticky", 32'(fault), 32'd1);

    // Single step: one instruction, then back to HALTED.
    step = 1'b1;
    step1("step_halted", v_halt);
    step = 1'b0;
    run_instr("step_add", 6'b000000, 1'b0, v_dec0, v_add);
    step1("step_back", v_halt);
    step1("step_stay", v_halt);
    chk("count13", 32'(instr_count), 32'd13);

    // Reset during EXECUTE suppresses the strobes of that cycle.
    run = 1'b1;
    step1("rx_start", v_halt);
    step1("rx_fetch", v(1, 0, 1, 0, 0, 0, 3'd0, 0));
    step1("rx_decode", v_dec0);
    reset = 1'b1; run = 1'b0;
    step1("rx_exec_reset", v(0, 0, 0, 0, 0, 0, 3'd0, 0));
    reset = 1'b0;
    chk("rx_count", 32'(instr_count), 32'd0);
    chk("rx_fault", 32'(fault), 32'd0);
    step1("rx_halted", v_halt);

    // Three-cycle memory stall, load on the fourth FETCH cycle.
    run = 1'b1; mem_ready = 1'b0; opcode = 6'b000000;
    step1("stall_start", v_halt);
    for (int i = 0; i < 3; i++) step1("stall_wait", v_wait);
    mem_ready = 1'b1;
    step1("stall_load", v(1, 0, 1, 0, 0, 0, 3'd0, 0));
    run = 1'b0;
    step1("stall_decode", v_dec0);
    step1("stall_exec", v_add);
    step1("stall_halt", v_halt);
    chk("stall_count", 32'(instr_count), 32'd1);
    chk("stall_fault", 32'(fault), 32'd0);

    // Fetch timeout: 14 idle cycles are tolerated, the 15th faults and halts.
    run = 1'b1; mem_ready = 1'b0;
    step1("tmo_start", v_halt);
    run = 1'b0;
    for (int i = 0; i < 14; i++) step1("tmo_wait", v_wait);
    chk("tmo_no_fault_yet", 32'(fault), 32'd0);
    step1("tmo_last", v_wait);
    chk("tmo_fault", 32'(fault), 32'd1);
    step1("tmo_halted", v_halt);
    chk("tmo_count", 32'(instr_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
